// File: rtl/risc_v_mem_pkg.sv
// risc_v_mem_pkg: shared FSM encodings and default tohost address for the data-memory responder
package risc_v_mem_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [31:0] TOHOST_DEFAULT = 32'd84;
endpackage

// File: rtl/dmem_ram_bank.sv
// dmem_ram_bank: DEPTH x 32 word array, byte-enable write, combinational read, no reset
module dmem_ram_bank #(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    // Commit only the enabled byte lanes of the addressed word
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with wait states and tohost decode
module data_mem_responder
    import risc_v_mem_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          LATENCY     = 0,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        test_done,
    output logic [31:0] test_value
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT = LATENCY[3:0];

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        in_idle, accept, enter_resp, ram_we, tohost_hit;
    logic        cur_write, cur_err;
    logic [31:0] cur_addr, cur_wdata, ram_rdata;
    logic [3:0]  cur_be;

    // With zero latency the commit happens on the accept edge, so the live
    // request fields are used in IDLE and the latched copy everywhere else.
    always_comb begin
        in_idle    = state == S_IDLE;
        accept     = req_valid && in_idle;
        cur_write  = in_idle ? req_write : write_q;
        cur_addr   = in_idle ? req_addr  : addr_q;
        cur_wdata  = in_idle ? req_wdata : wdata_q;
        cur_be     = in_idle ? req_be    : be_q;
        cur_err    = cur_addr[1:0] != 2'b00;
        enter_resp = (accept && LAT == 4'd0) || (state == S_WAIT && cnt == 4'd0);
        ram_we     = enter_resp && cur_write && !cur_err;
        tohost_hit = ram_we && cur_addr == TOHOST_ADDR && cur_be == 4'hF;
    end

    dmem_ram_bank #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cur_addr[AW+1:2]),
        .be    (cur_be),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    // Request sequencing: latch on accept, count wait states, one-cycle response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else if (state == S_IDLE) begin
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                cnt     <= LAT == 4'd0 ? 4'd0 : LAT - 4'd1;
                state   <= LAT == 4'd0 ? S_RESP : S_WAIT;
            end
        end else if (state == S_WAIT) begin
            cnt   <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
            state <= cnt == 4'd0 ? S_RESP : S_WAIT;
        end else begin
            state <= S_IDLE;
        end
    end

    // Sticky completion flag captures only the first full-word tohost store
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            test_done  <= 1'b0;
            test_value <= 32'd0;
        end else if (tohost_hit && !test_done) begin
            test_done  <= 1'b1;
            test_value <= cur_wdata;
        end
    end

    assign req_ready  = in_idle;
    assign resp_valid = state == S_RESP;
    assign resp_err   = resp_valid && cur_err;
    assign resp_rdata = (resp_valid && !write_q && !cur_err) ? ram_rdata : 32'd0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed tests for zero-latency and three-wait-state responders
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset0, reset3, valid0, valid3;
    logic        write;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        rdy0, rv0, err0, done0, rdy3, rv3, err3, done3;
    logic [31:0] rd0, val0, rd3, val3;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .reset(reset0), .req_valid(valid0), .req_ready(rdy0),
        .req_write(write), .req_addr(addr), .req_wdata(wdata), .req_be(be),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0),
        .test_done(done0), .test_value(val0)
    );

    data_mem_responder #(.LATENCY(3)) dut3 (
        .clk(clk), .reset(reset3), .req_valid(valid3), .req_ready(rdy3),
        .req_write(write), .req_addr(addr), .req_wdata(wdata), .req_be(be),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3),
        .test_done(done3), .test_value(val3)
    );

    // Issue one request to the selected responder from IDLE; returns data,
    // error and the cycle (counted from the accept edge) where resp_valid rose.
    task automatic req(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic er, output int lat);
        write = w; addr = a; wdata = d; be = b;
        if (sel) valid3 = 1'b1; else valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0; valid3 = 1'b0;
        write = ~w; addr = 32'hFFFF_FFF3; wdata = 32'hBAD0_BAD0; be = 4'hF;
        lat = 1;
        while (!(sel ? rv3 : rv0) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = sel ? rd3 : rd0;
        er = sel ? err3 : err0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset0 = 1'b0; reset3 = 1'b0; valid0 = 1'b0; valid3 = 1'b0;
        write = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", rdy0); end
        total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rv0); end
        total++; if (rd0 !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rd0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err0); end
        total++; if (done0 !== 1'b0 || done3 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b%b want=00", done0, done3); end
        total++; if (val0 !== 32'd0) begin bad++; $display("FAIL reset_value got=%h want=0", val0); end
        reset0 = 1'b1; reset3 = 1'b1;
    endtask

    task automatic test_tohost_l0();
        logic [31:0] rd; logic er; int lat;
        req(0, 1'b1, 32'd84, 32'd71, 4'hF, rd, er, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL tohost_latency got=%0d want=1", lat); end
        total++; if (er !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL tohost_resp got=%b/%h want=0/0", er, rd); end
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL tohost_done got=%b want=1", done0); end
        total++; if (val0 !== 32'd71) begin bad++; $display("FAIL tohost_value got=%0d want=71", val0); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        req(0, 1'b1, 32'd8, 32'h1122_3344, 4'hF, rd, er, lat);
        req(0, 1'b1, 32'd8, 32'h0000_00AA, 4'h1, rd, er, lat);
        req(0, 1'b0, 32'd8, 32'd0, 4'hF, rd, er, lat);
        total++; if (rd !== 32'h1122_33AA) begin bad++; $display("FAIL byte_enable got=%h want=112233aa", rd); end
        req(0, 1'b1, 32'd8, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
        total++; if (lat !== 1 || er !== 1'b0) begin bad++; $display("FAIL be_zero_resp got=%0d/%b want=1/0", lat, er); end
        req(0, 1'b0, 32'd8, 32'd0, 4'hF, rd, er, lat);
        total++; if (rd !== 32'h1122_33AA) begin bad++; $display("FAIL be_zero_noop got=%h want=112233aa", rd); end
    endtask

    task automatic test_latency3();
        logic [31:0] rd; logic er; int lat;
        req(1, 1'b1, 32'd0, 32'h0BAD_F00D, 4'hF, rd, er, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL l3_store_latency got=%0d want=4", lat); end
        write = 1'b0; addr = 32'd0; be = 4'hF; valid3 = 1'b1;
        total++; if (rdy3 !== 1'b1) begin bad++; $display("FAIL l3_ready_before got=%b want=1", rdy3); end
        @(posedge clk); #1;
        valid3 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            total++; if (rdy3 !== 1'b0) begin bad++; $display("FAIL l3_ready_busy cycle=%0d got=%b want=0", i, rdy3); end
            total++; if (rv3 !== (i == 4)) begin bad++; $display("FAIL l3_valid cycle=%0d got=%b want=%b", i, rv3, i == 4); end
            if (i < 4) begin @(posedge clk); #1; end
        end
        total++; if (rd3 !== 32'h0BAD_F00D) begin bad++; $display("FAIL l3_rdata got=%h want=0badf00d", rd3); end
        @(posedge clk); #1;
        total++; if (rdy3 !== 1'b1 || rv3 !== 1'b0) begin bad++; $display("FAIL l3_ready_after got=%b/%b want=1/0", rdy3, rv3); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat;
        req(0, 1'b1, 32'd4, 32'h1234_5678, 4'hF, rd, er, lat);
        req(0, 1'b1, 32'd6, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin bad++; $display("FAIL misaligned_store got=%b/%h/%0d want=1/0/1", er, rd, lat); end
        req(0, 1'b0, 32'd5, 32'd0, 4'hF, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL misaligned_load got=%b/%h want=1/0", er, rd); end
        req(0, 1'b0, 32'd4, 32'd0, 4'hF, rd, er, lat);
        total++; if (er !== 1'b0 || rd !== 32'h1234_5678) begin bad++; $display("FAIL misaligned_nochange got=%b/%h want=0/12345678", er, rd); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er; int lat;
        req(1, 1'b1, 32'd84, 32'h55, 4'hF, rd, er, lat);
        total++; if (done3 !== 1'b1 || val3 !== 32'h55) begin bad++; $display("FAIL l3_tohost got=%b/%h want=1/55", done3, val3); end
        write = 1'b1; addr = 32'd84; wdata = 32'h99; be = 4'hF; valid3 = 1'b1;
        @(posedge clk); #1;
        valid3 = 1'b0;
        @(posedge clk); #1;
        reset3 = 1'b0;
        #1;
        total++; if (done3 !== 1'b0 || val3 !== 32'd0) begin bad++; $display("FAIL wait_reset_done got=%b/%h want=0/0", done3, val3); end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) reset3 = 1'b1;
            total++; if (rv3 !== 1'b0) begin bad++; $display("FAIL wait_reset_noresp cycle=%0d got=%b want=0", i, rv3); end
            @(posedge clk); #1;
        end
        total++; if (rdy3 !== 1'b1) begin bad++; $display("FAIL wait_reset_idle got=%b want=1", rdy3); end
        req(1, 1'b0, 32'd84, 32'd0, 4'hF, rd, er, lat);
        total++; if (rd !== 32'h55) begin bad++; $display("FAIL wait_reset_ram got=%h want=55", rd); end
        total++; if (done3 !== 1'b0) begin bad++; $display("FAIL wait_reset_done_after got=%b want=0", done3); end
    endtask

    task automatic test_sticky_alias();
        logic [31:0] rd; logic er; int lat;
        reset0 = 1'b0;
        @(posedge clk); #1;
        reset0 = 1'b1;
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL rereset_done got=%b want=0", done0); end
        req(0, 1'b1, 32'd84, 32'd5, 4'hF, rd, er, lat);
        req(0, 1'b1, 32'd84, 32'd9, 4'hF, rd, er, lat);
        total++; if (done0 !== 1'b1 || val0 !== 32'd5) begin bad++; $display("FAIL sticky_value got=%b/%0d want=1/5", done0, val0); end
        req(0, 1'b0, 32'd84, 32'd0, 4'hF, rd, er, lat);
        total++; if (rd !== 32'd9) begin bad++; $display("FAIL sticky_ram got=%0d want=9", rd); end
        req(0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL alias_err got=%b want=0", er); end
        req(0, 1'b0, 32'd0, 32'd0, 4'hF, rd, er, lat);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL alias_load got=%h want=deadbeef", rd); end
    endtask

    initial begin
        test_reset();
        test_tohost_l0();
        test_byte_enable();
        test_latency3();
        test_misaligned();
        test_reset_in_wait();
        test_sticky_alias();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
